// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int             XLEN      = 32;
    localparam int             CNT_W     = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

    function automatic logic is_zero_op(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        return (x == '0) || (y == '0);
    endfunction

endpackage

// File: rtl/fulladd32.sv
// 32-bit ripple-style full adder shared by all partial-product additions.
module FULLADD32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] X,
    output logic        cout
);

    assign {cout, X} = {1'b0, A} + {1'b0, B} + {32'b0, cin};

endmodule

// File: rtl/mul32_ctrl.sv
// Multiplier sequencer: FSM, iteration counter and registered ready/busy/done.
module mul32_ctrl
    import mul_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_zero,
    output state_t           o_state,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_zero  <= ZERO_SKIP && i_zero;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A zero operand leaves after a single RUN cycle
                    if (r_zero || (r_cnt == ITER_LAST)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_state = r_state;
    assign o_cnt   = r_cnt;
    assign o_zero  = r_zero;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32 unsigned multiplier, one add-and-shift per clock on a
// single shared FULLADD32; 64-bit product presented with a one-cycle done.
module mul32_seq
    import mul_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] prod
);

    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_acc_hi;
    logic [XLEN-1:0]   r_acc_lo;
    logic [2*XLEN-1:0] r_prod;

    state_t            w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_zero;
    logic [XLEN-1:0]   w_add_b;
    logic [XLEN-1:0]   w_x;
    logic              w_cout;
    logic [2*XLEN-1:0] w_shift;

    mul32_ctrl #(.ZERO_SKIP(ZERO_SKIP)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start),
        .i_zero  (is_zero_op(a, b)),
        .o_state (w_state),
        .o_cnt   (w_cnt),
        .o_zero  (w_zero),
        .o_ready (ready),
        .o_busy  (busy),
        .o_done  (done)
    );

    assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

    FULLADD32 u_add (
        .A    (r_acc_hi),
        .B    (w_add_b),
        .cin  (1'b0),
        .X    (w_x),
        .cout (w_cout)
    );

    // Carry-out becomes the new MSB, so the 65-bit sum shifts right without loss
    assign w_shift = {w_cout, w_x, r_acc_lo[XLEN-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_prod   <= '0;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                    end
                end
                ST_RUN: begin
                    if (w_zero) begin
                        r_prod <= '0;
                    end else begin
                        {r_acc_hi, r_acc_lo} <= w_shift;
                        if (w_cnt == ITER_LAST) r_prod <= w_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod = r_prod;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed cases plus random operands
// against a plain 64-bit multiply reference.
module tb_mul32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start0 = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        ready1, busy1, done1;
    logic [63:0] prod1;
    logic        ready0, busy0, done0;
    logic [63:0] prod0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul32_seq #(.ZERO_SKIP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
        .ready(ready1), .busy(busy1), .done(done1), .prod(prod1)
    );

    mul32_seq #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
        .ready(ready0), .busy(busy0), .done(done0), .prod(prod0)
    );

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic g_done(input bit sel);
        return sel ? done0 : done1;
    endfunction
    function automatic logic g_ready(input bit sel);
        return sel ? ready0 : ready1;
    endfunction
    function automatic logic g_busy(input bit sel);
        return sel ? busy0 : busy1;
    endfunction
    function automatic logic [63:0] g_prod(input bit sel);
        return sel ? prod0 : prod1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // sel=0 drives the zero-skip instance, sel=1 the full-length one
    task automatic run_op(input bit sel, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [63:0] old;
        int cyc;
        int lat;
        old = g_prod(sel);
        lat = (!sel && (x == 0 || y == 0)) ? 1 : 32;
        @(negedge clk);
        a = x; b = y;
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        check({tag, "_busy"}, 64'(g_busy(sel)), 64'd1);
        check({tag, "_notready"}, 64'(g_ready(sel)), 64'd0);
        cyc = 0;
        while (!g_done(sel) && cyc < 40) begin
            check({tag, "_hold"}, g_prod(sel), old);
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_prod"}, g_prod(sel), model(x, y));
        check({tag, "_rdy_in_done"}, 64'(g_ready(sel)), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 64'(g_done(sel)), 64'd0);
        check({tag, "_ready_back"}, 64'(g_ready(sel)), 64'd1);
        check({tag, "_prod_stable"}, g_prod(sel), model(x, y));
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] x, y;
        int ndone;
        int done_at;

        #12;
        check("rst_ready", 64'(ready1), 64'd1);
        check("rst_busy",  64'(busy1),  64'd0);
        check("rst_done",  64'(done1),  64'd0);
        check("rst_prod",  prod1,       64'd0);
        check("rst_prod0", prod0,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 32'd3, 32'd5, "m3x5");
        check("m3x5_const", prod1, 64'h0000_0000_0000_000F);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mff");
        check("mff_const", prod1, 64'hFFFF_FFFE_0000_0001);
        run_op(1'b0, 32'h1234_5678, 32'h8765_4321, "m1234");
        check("m1234_const", prod1, 64'h09A0_CD05_70B8_8D78);
        run_op(1'b0, 32'd1, 32'd1, "m1x1");
        check("m1x1_const", prod1, 64'd1);

        run_op(1'b0, 32'd0, 32'hFFFF_FFFF, "zskip");
        run_op(1'b1, 32'd0, 32'hFFFF_FFFF, "nozskip");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd0, "zskip_b");

        // start pulses while RUN and DONE must be ignored
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h0000_1234; start1 = 1'b1;
        exp = model(32'hDEAD_BEEF, 32'h0000_1234);
        @(posedge clk); #1;
        start1 = 1'b0;
        ndone = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                a = $urandom; b = $urandom; start1 = 1'b1;
            end else if (done1) begin
                start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            @(posedge clk); #1;
            if (done1) begin
                ndone++;
                done_at = c;
            end
        end
        start1 = 1'b0;
        check("ign_ndone", 64'(ndone), 64'd1);
        check("ign_lat", 64'(done_at), 64'd32);
        check("ign_prod", prod1, exp);
        check("ign_idle", 64'(ready1), 64'd1);
        check("ign_notbusy", 64'(busy1), 64'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 32'd7; b = 32'd9; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mrst_ready", 64'(ready1), 64'd1);
        check("mrst_busy",  64'(busy1),  64'd0);
        check("mrst_done",  64'(done1),  64'd0);
        check("mrst_prod",  prod1,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        check("mrst_nodone", 64'(ndone), 64'd0);
        run_op(1'b0, 32'hCAFE_0001, 32'h0BAD_F00D, "post_rst");

        for (int i = 0; i < 8; i++) begin
            x = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(1'b0, x, y, "rnd");
        end
        for (int i = 0; i < 3; i++) begin
            x = $urandom;
            y = (i == 0) ? 32'd0 : $urandom;
            run_op(1'b1, x, y, "rnd0");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
